// File: rtl/zephyr_pkg.sv
// Shared constants, state encoding and state names for the zephyr boot loader.
// The CLEAR state is only reachable when ZEPHYR_BOOT_CLEAR_EN is defined.
package zephyr_pkg;

    localparam int ZEPHYR_DATA_W    = 8;
    localparam int ZEPHYR_ADDR_W    = 4;
    localparam int ZEPHYR_RAM_DEPTH = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LENGTH = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_CLEAR  = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LENGTH = ST_LENGTH,
        DATA   = ST_DATA,
        CHECK  = ST_CHECK,
        CLEAR  = ST_CLEAR,
        RUN    = ST_RUN,
        ERROR  = ST_ERROR
    } state_t;

    function automatic string state_name(input state_t s);
        case (s)
            IDLE:    return "IDLE";
            LENGTH:  return "LENGTH";
            DATA:    return "DATA";
            CHECK:   return "CHECK";
            CLEAR:   return "CLEAR";
            RUN:     return "RUN";
            ERROR:   return "ERROR";
            default: return "UNKNOWN";
        endcase
    endfunction

endpackage

// File: rtl/zephyr_boot_loader.sv
// Framed program loader for zephyr RAM: LEN, N data bytes, SUM; holds CPU in reset.
// Define ZEPHYR_BOOT_CLEAR_EN to zero-fill addresses N..15 after a good load.
module zephyr_boot_loader
    import zephyr_pkg::*;
#(
    parameter int DATA_W    = ZEPHYR_DATA_W,
    parameter int ADDR_W    = ZEPHYR_ADDR_W,
    parameter int RAM_DEPTH = ZEPHYR_RAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RAM_DEPTH - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] idx, idx_d;
    logic [ADDR_W-1:0] len, len_d;
    logic [DATA_W-1:0] sum, sum_d;
    logic [DATA_W-1:0] sum_fin;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              we_d, done_d, err_d, xfer;

    assign in_ready = (state == LENGTH) || (state == DATA) || (state == CHECK);
    assign xfer     = in_valid && in_ready;
    assign sum_fin  = sum + in_data;

    always_comb begin
        state_d = state;
        idx_d   = idx;
        len_d   = len;
        sum_d   = sum;
        we_d    = 1'b0;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;
        unique case (state)
            IDLE: begin
                if (start) state_d = LENGTH;
            end
            LENGTH: begin
                if (xfer) begin
                    len_d   = in_data[ADDR_W-1:0];
                    sum_d   = in_data;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    sum_d   = sum_fin;
                    we_d    = 1'b1;
                    addr_d  = idx;
                    wdata_d = in_data;
                    idx_d   = idx + ONE;
                    // len==0 encodes a full image, so len-1 wraps to LAST
                    if (idx == len - ONE) state_d = CHECK;
                end
            end
            CHECK: begin
                if (xfer) begin
                    sum_d = sum_fin;
                    if (sum_fin != '0) begin
                        state_d = ERROR;
                    end else begin
`ifdef ZEPHYR_BOOT_CLEAR_EN
                        state_d = (len == '0) ? RUN : CLEAR;
`else
                        state_d = RUN;
`endif
                    end
                end
            end
`ifdef ZEPHYR_BOOT_CLEAR_EN
            CLEAR: begin
                we_d    = 1'b1;
                addr_d  = idx;
                wdata_d = '0;
                idx_d   = idx + ONE;
                if (idx == LAST) state_d = RUN;
            end
`endif
            RUN: begin
                if (start) state_d = LENGTH;
            end
            ERROR: begin
                if (start) state_d = LENGTH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_d = (state == RUN) && !start;
    assign err_d  = ((state == CHECK) && xfer && (sum_fin != '0))
                 || ((state == ERROR) && !start);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            len       <= '0;
            sum       <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            len       <= len_d;
            sum       <= sum_d;
            ram_we    <= we_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            cpu_reset <= !done_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_zephyr_boot_loader.sv
// Self-checking bench for zephyr_boot_loader: frame table plus write scoreboard.
// Expectations follow ZEPHYR_BOOT_CLEAR_EN when it is defined for the build.
module tb_zephyr_boot_loader;
    import zephyr_pkg::*;

`ifdef ZEPHYR_BOOT_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, ram_we, cpu_reset, done, err;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;

    always #5 clk = ~clk;

    zephyr_boot_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [7:0]       len;
        logic [15:0][7:0] data;
        logic [7:0]       sum;
        bit               good;
        int               gap;
    } frame_t;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    int         we_cnt = 0;
    wr_t        exp_q[$];
    logic [7:0] tb_ram [16];
    logic [7:0] exp_ram[16];
    frame_t     tbl[6];

    // RAM model plus write scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_t w;
            we_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ram_write_unexpected: got addr=%0d data=%h, required no write",
                         ram_addr, ram_wdata);
            end else begin
                w = exp_q.pop_front();
                if (w.a !== ram_addr || w.d !== ram_wdata) begin
                    errors++;
                    $display("FAIL ram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             ram_addr, ram_wdata, w.a, w.d);
                end
            end
            tb_ram[ram_addr] = ram_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_ram(input string name);
        int bad = -1;
        for (int i = 0; i < 16; i++)
            if (tb_ram[i] !== exp_ram[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: RAM[%0d] got %h, required %h",
                     name, bad, tb_ram[bad], exp_ram[bad]);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int c = 0;
        while (in_ready !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        if (c == 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=%b, required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (gap) tick();
    endtask

    task automatic push_wr(input int a, input logic [7:0] d);
        exp_q.push_back({4'(a), d});
        exp_ram[a] = d;
    endtask

    task automatic run_frame(input frame_t f, input int id);
        int n, c, wbase, ew, nclr, lat;
        n     = (f.len[3:0] == 4'd0) ? 16 : int'(f.len[3:0]);
        nclr  = (f.good && CLEAR_EN && n < 16) ? 16 - n : 0;
        ew    = n + nclr;
        wbase = we_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("f%0d_start_ready", id), in_ready, 1);
        check($sformatf("f%0d_start_err", id), err, 0);
        check($sformatf("f%0d_start_done", id), done, 0);
        check($sformatf("f%0d_start_cpu_reset", id), cpu_reset, 1);
        send(f.len, f.gap);
        for (int k = 0; k < n; k++) begin
            push_wr(k, f.data[k]);
            send(f.data[k], f.gap);
        end
        for (int a = n; a < n + nclr; a++) push_wr(a, 8'h00);
        send(f.sum, 0);
        c = 0;
        while (!(done === 1'b1 || err === 1'b1) && c < 40) begin
            tick();
            c++;
        end
        lat = f.good ? 1 + nclr : 0;
        check($sformatf("f%0d_latency", id), c, lat);
        check($sformatf("f%0d_done", id), done, f.good);
        check($sformatf("f%0d_err", id), err, !f.good);
        check($sformatf("f%0d_cpu_reset", id), cpu_reset, !f.good);
        check($sformatf("f%0d_ready_idle", id), in_ready, 0);
        check($sformatf("f%0d_queue_empty", id), exp_q.size(), 0);
        check($sformatf("f%0d_we_count", id), we_cnt - wbase, ew);
        check_ram($sformatf("f%0d_ram", id));
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            tb_ram[i]  = 8'hEE;
            exp_ram[i] = 8'hEE;
        end

        foreach (tbl[i]) begin
            tbl[i].data = '0;
            tbl[i].gap  = 0;
            tbl[i].good = 1'b1;
        end
        tbl[0].len = 8'h04;
        tbl[0].data[0] = 8'h4C; tbl[0].data[1] = 8'h5D;
        tbl[0].data[2] = 8'h6E; tbl[0].data[3] = 8'h7F;
        tbl[0].sum = 8'h66;
        tbl[1] = tbl[0];
        tbl[1].sum  = 8'h67;
        tbl[1].good = 1'b0;
        tbl[2].len = 8'h00;
        for (int i = 0; i < 16; i++) tbl[2].data[i] = 8'(i);
        tbl[2].sum = 8'h88;
        tbl[3] = tbl[0];
        tbl[3].gap = 3;
        tbl[4].len = 8'h12;
        tbl[4].data[0] = 8'h10; tbl[4].data[1] = 8'h20;
        tbl[4].sum = 8'hBE;
        tbl[5].len = 8'h01;
        tbl[5].data[0] = 8'hAA;
        tbl[5].sum = 8'h55;

        repeat (2) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        tick();
        check("idle_cpu_reset", cpu_reset, 1);
        check("idle_ready", in_ready, 0);

        for (int i = 0; i < 6; i++) run_frame(tbl[i], i);

        // abandon a frame after two data bytes
        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'h04, 0);
        push_wr(0, 8'h11);
        send(8'h11, 0);
        push_wr(1, 8'h22);
        send(8'h22, 0);
        reset = 1'b0;
        tick();
        check("mid_in_ready", in_ready, 0);
        check("mid_ram_we", ram_we, 0);
        check("mid_ram_addr", ram_addr, 0);
        check("mid_ram_wdata", ram_wdata, 0);
        check("mid_cpu_reset", cpu_reset, 1);
        check("mid_done", done, 0);
        check("mid_err", err, 0);
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL mid_state: got %s, required IDLE", state_name(dut.state));
        end
        reset = 1'b1;
        repeat (3) tick();
        check("mid_ram_we_after", ram_we, 0);
        check("mid_queue_empty", exp_q.size(), 0);
        check_ram("mid_ram");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zephyr_boot_loader.md
Name: zephyr_boot_loader

Overview:
Upstream program-load stage for the zephyr CPU. It accepts a framed byte stream over a valid/ready handshake and writes the program image into the 16-byte zephyr RAM through its write port. It holds the CPU in reset while loading and verifies an 8-bit checksum. On success it releases the CPU so execution starts at PC 0 with a known image.

Parameters:
DATA_W, 8, data byte and RAM word width
ADDR_W, 4, RAM address width
RAM_DEPTH, 16, number of RAM words; must equal 2**ADDR_W

Ports:
CLK  input  1  system clock, all logic rising-edge
RESET  input  1  synchronous, active-low reset
START  input  1  one-cycle pulse that begins a load; sampled in IDLE, RUN and ERROR
IN_VALID  input  1  upstream byte valid
IN_DATA  input  DATA_W  upstream byte
IN_READY  output  1  loader can accept a byte this cycle
RAM_WE  output  1  RAM write strobe, one cycle per word
RAM_ADDR  output  ADDR_W  RAM write address
RAM_WDATA  output  DATA_W  RAM write data
CPU_RESET  output  1  active-high reset to zephyr CPU
DONE  output  1  image loaded and verified; CPU running
ERR  output  1  checksum failure latched

Behaviour:
- Reset (RESET=0 at a clock edge) forces the following values. State=IDLE. IN_READY=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0, CPU_RESET=1, DONE=0, ERR=0. Byte index=0, length=0, sum=0.
- Reset mid-load abandons the frame. RAM contents already written stay as they are.
- A transfer occurs when IN_VALID=1 and IN_READY=1 at a rising edge. IN_DATA is ignored otherwise. IN_VALID may drop at any time without penalty.
- Frame format: one LEN byte, then N data bytes, then one SUM byte.
  - N = LEN[ADDR_W-1:0]. N=0 encodes 16. LEN[7:4] is ignored but is still included in the sum.
  - The frame is valid iff the 8-bit modular sum of LEN, all data bytes and SUM equals 8'h00.
- States:
  - IDLE: IN_READY=0, CPU_RESET=1. START moves to LENGTH on the next edge.
  - LENGTH: IN_READY=1. On transfer, latch N and set sum=IN_DATA → DATA.
  - DATA: IN_READY=1. On transfer k (k=0..N-1), sum+=IN_DATA. Register RAM_WE=1, RAM_ADDR=k, RAM_WDATA=IN_DATA so they are valid the following cycle only. After byte N-1 → CHECK.
  - CHECK: IN_READY=1. On transfer, compute the final sum. Zero → RUN (or CLEAR, see Optional Feature). Non-zero → ERROR.
  - RUN: IN_READY=0, DONE=1, CPU_RESET=0 starting the cycle after entry. START → LENGTH, with CPU_RESET=1 and DONE=0 in the very next cycle.
  - ERROR: IN_READY=0, ERR=1, CPU_RESET=1. START → LENGTH and clears ERR.
- RAM_WE is deasserted in every cycle that does not immediately follow a data-byte transfer. At most one write per cycle.
- Latency rules:
  - Data byte accepted at edge t is written into RAM at edge t+1.
  - After the SUM byte is accepted at edge t, CPU_RESET falls after edge t+1. The CPU begins FETCH at the edge following that.
- IN_READY is a registered function of state only; it never depends on IN_VALID combinationally.
- START in LENGTH, DATA, CHECK or CLEAR is ignored.
- Address wrap: the index never exceeds N-1. N=16 writes addresses 0..15 with no wrap.

Optional Feature:
Macro ZEPHYR_BOOT_CLEAR_EN.
- Defined: after a good checksum with N<16, enter CLEAR. In CLEAR, IN_READY=0 and the block writes 8'h00 to addresses N..15, one per cycle (RAM_WE=1), then goes to RUN. N=16 skips CLEAR.
- Undefined: the CLEAR state is not built. Addresses N..15 keep their prior contents and a good checksum goes directly to RUN.

Decomposition:
- Shared package zephyr_pkg holds:
  - ZEPHYR_DATA_W, ZEPHYR_ADDR_W, ZEPHYR_RAM_DEPTH constants.
  - State encoding localparams for IDLE, LENGTH, DATA, CHECK, CLEAR, RUN, ERROR (3 bits).
  - The value-to-string mapping the bench uses for state display.
- No sub-module. The checksum accumulator is a single 8-bit register inside the FSM.

Test Plan:
- Basic load:
  - Stimulus: START, then stream 04,4C,5D,6E,7F,66 with IN_VALID held.
  - Response: RAM[0..3]=4C,5D,6E,7F and exactly 4 RAM_WE pulses. DONE=1, ERR=0, CPU_RESET=0 two cycles after the 66 transfer.
- Bad checksum:
  - Stimulus: same frame with last byte 67.
  - Response: ERR=1, DONE=0, CPU_RESET stays 1. A following START clears ERR and reaches LENGTH.
- Full image:
  - Stimulus: LEN=00, 16 bytes 00..0F, SUM=0x88.
  - Response: RAM[i]=i for i=0..15, DONE=1. With ZEPHYR_BOOT_CLEAR_EN defined, no CLEAR writes occur.
- Backpressure/gaps:
  - Stimulus: basic frame with IN_VALID low for 3 cycles between every byte.
  - Response: identical RAM contents. No RAM_WE during gaps.
- Reset mid-load:
  - Stimulus: drop RESET low for one edge after 2 data bytes.
  - Response: all outputs at reset values and the state is IDLE. RAM[0..1] hold the written bytes, RAM[2..3] are unchanged.
- Restart from RUN with clear enabled:
  - Stimulus: START in RUN, then frame 01,AA,55 with ZEPHYR_BOOT_CLEAR_EN defined.
  - Response: CPU_RESET=1 the next cycle, RAM[0]=AA, RAM[1..15]=00 via 15 consecutive RAM_WE cycles, then DONE=1.
